// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file operation sequencer.
package regfile_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MOV = 3'd5,
    OP_LDI = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  typedef struct packed {
    op_e             op;
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [DW-1:0]   imm;
  } cmd_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU: unsigned wrap-around arithmetic/logic with zero and carry/borrow flags.
module regfile_alu
  import regfile_pkg::*;
(
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] imm,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow, i.e. a < b unsigned.
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result = sum[DW-1:0];
        carry  = sum[DW];
      end
      OP_SUB, OP_CMP: begin
        result = diff[DW-1:0];
        carry  = diff[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Command-driven sequencer: IDLE -> EXEC (read + ALU) -> WB (write + response) per command.
module regfile_op_sequencer #(
  parameter int unsigned DW = regfile_pkg::DW,
  parameter int unsigned AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs1,
  input  logic [AW-1:0] cmd_rs2,
  input  logic [DW-1:0] cmd_imm,
  output logic [AW-1:0] rf_addre_rdA,
  output logic [AW-1:0] rf_addre_rdB,
  input  logic [DW-1:0] rf_QA,
  input  logic [DW-1:0] rf_QB,
  output logic [DW-1:0] rf_D,
  output logic [AW-1:0] rf_addre_wr,
  output logic          rf_we,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_carry
);
  import regfile_pkg::*;

  state_e        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [AW-1:0] rda_q, rda_d;
  logic [AW-1:0] rdb_q, rdb_d;
  logic [DW-1:0] res_q, res_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;

  logic [DW-1:0] alu_result;
  logic          alu_zero;
  logic          alu_carry;
  logic          in_wb;

  regfile_alu u_alu (
    .op     (cmd_q.op),
    .a      (rf_QA),
    .b      (rf_QB),
    .imm    (cmd_q.imm),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rda_d     = rda_q;
    rdb_d     = rdb_q;
    res_d     = res_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    cmd_ready = (state_q == S_IDLE) && !rst;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.op  = op_e'(cmd_op);
          cmd_d.rd  = cmd_rd;
          cmd_d.rs1 = cmd_rs1;
          cmd_d.rs2 = cmd_rs2;
          cmd_d.imm = cmd_imm;
          // Read addresses are loaded at acceptance so they are stable for the whole EXEC cycle.
          rda_d     = cmd_rs1;
          rdb_d     = cmd_rs2;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      rda_q   <= '0;
      rdb_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    in_wb        = (state_q == S_WB);
    rf_addre_rdA = rda_q;
    rf_addre_rdB = rdb_q;
    rf_we        = in_wb && (cmd_q.op != OP_CMP);
    rf_addre_wr  = in_wb ? cmd_q.rd : '0;
    rf_D         = in_wb ? res_q : '0;
    rsp_valid    = in_wb;
    rsp_data     = in_wb ? res_q : '0;
    rsp_zero     = in_wb && zero_q;
    rsp_carry    = in_wb && carry_q;
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed self-checking bench for regfile_op_sequencer with a behavioural 8x16 register file.
module tb_regfile_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [15:0] cmd_imm;
  logic [2:0]  rf_addre_rdA, rf_addre_rdB, rf_addre_wr;
  logic [15:0] rf_QA, rf_QB, rf_D;
  logic        rf_we;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_zero, rsp_carry;

  logic [15:0] rf [8] = '{default: 16'h0000};

  int n_checks = 0;
  int n_fail   = 0;

  // captured per-command observations
  logic        o_rdy_exec, o_v_exec, o_v_wb, o_we_wb, o_z, o_c, o_rdy_after;
  logic [2:0]  o_wa;
  logic [15:0] o_data;

  regfile_op_sequencer #(.DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rf_addre_rdA(rf_addre_rdA), .rf_addre_rdB(rf_addre_rdB),
    .rf_QA(rf_QA), .rf_QB(rf_QB), .rf_D(rf_D), .rf_addre_wr(rf_addre_wr), .rf_we(rf_we),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;

  assign rf_QA = rf[rf_addre_rdA];
  assign rf_QB = rf[rf_addre_rdB];
  always @(posedge clk) if (rf_we) rf[rf_addre_wr] <= rf_D;

  // Issue one command when ready; record EXEC, WB and post-WB observations.
  task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] imm);
    int unsigned waited = 0;
    while (!cmd_ready && waited < 10) begin
      @(posedge clk); #1; waited++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    o_rdy_exec = cmd_ready;
    o_v_exec   = rsp_valid;
    @(posedge clk); #1;
    o_v_wb = rsp_valid; o_we_wb = rf_we; o_wa = rf_addre_wr;
    o_data = rsp_data;  o_z = rsp_zero;  o_c = rsp_carry;
    @(posedge clk); #1;
    o_rdy_after = cmd_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_t0: got %b exp 0", cmd_ready); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", cmd_ready); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b exp 0", rf_we); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
      n_checks++; if ({rf_D, rsp_data} !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h/%h exp 0/0", rf_D, rsp_data); end
      n_checks++; if ({rf_addre_rdA, rf_addre_rdB, rf_addre_wr} !== 9'h0) begin n_fail++; $display("FAIL rst_addr: got %h %h %h exp 0", rf_addre_rdA, rf_addre_rdB, rf_addre_wr); end
      n_checks++; if ({rsp_zero, rsp_carry} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b%b exp 00", rsp_zero, rsp_carry); end
    end
    rst = 1'b0; #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b exp 1", cmd_ready); end
    @(posedge clk); #1;
    n_checks++; if ({cmd_ready, rf_we, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL idle_outputs: got %b exp 100", {cmd_ready, rf_we, rsp_valid}); end
  endtask

  task automatic test_ldi_mov;
    run_cmd(3'd6, 3'd3, 3'd0, 3'd0, 16'h1234);
    n_checks++; if ({o_rdy_exec, o_v_exec} !== 2'b00) begin n_fail++; $display("FAIL ldi_exec: ready,valid got %b exp 00", {o_rdy_exec, o_v_exec}); end
    n_checks++; if ({o_v_wb, o_we_wb} !== 2'b11) begin n_fail++; $display("FAIL ldi_wb: valid,we got %b exp 11", {o_v_wb, o_we_wb}); end
    n_checks++; if (o_wa !== 3'd3) begin n_fail++; $display("FAIL ldi_waddr: got %0d exp 3", o_wa); end
    n_checks++; if (o_data !== 16'h1234) begin n_fail++; $display("FAIL ldi_data: got %h exp 1234", o_data); end
    n_checks++; if (o_rdy_after !== 1'b1) begin n_fail++; $display("FAIL ldi_ready_back: got %b exp 1", o_rdy_after); end
    n_checks++; if (rf[3] !== 16'h1234) begin n_fail++; $display("FAIL ldi_r3: got %h exp 1234", rf[3]); end
    run_cmd(3'd5, 3'd5, 3'd3, 3'd0, 16'h0000);
    n_checks++; if ({o_v_exec, o_v_wb, o_we_wb, o_rdy_after} !== 4'b0111) begin n_fail++; $display("FAIL mov_timing: got %b exp 0111", {o_v_exec, o_v_wb, o_we_wb, o_rdy_after}); end
    n_checks++; if (o_data !== 16'h1234) begin n_fail++; $display("FAIL mov_data: got %h exp 1234", o_data); end
    n_checks++; if (rf[5] !== 16'h1234) begin n_fail++; $display("FAIL mov_r5: got %h exp 1234", rf[5]); end
    n_checks++; if (rf_addre_rdA !== 3'd3) begin n_fail++; $display("FAIL rdA_hold: got %0d exp 3", rf_addre_rdA); end
  endtask

  task automatic test_add_carry;
    run_cmd(3'd6, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    n_checks++; if ({o_z, o_c} !== 2'b00) begin n_fail++; $display("FAIL ldi_flags: got %b exp 00", {o_z, o_c}); end
    run_cmd(3'd6, 3'd2, 3'd0, 3'd0, 16'h0001);
    run_cmd(3'd0, 3'd4, 3'd1, 3'd2, 16'h0000);
    n_checks++; if (o_data !== 16'h0000) begin n_fail++; $display("FAIL add_data: got %h exp 0000", o_data); end
    n_checks++; if ({o_z, o_c} !== 2'b11) begin n_fail++; $display("FAIL add_flags: zero,carry got %b exp 11", {o_z, o_c}); end
    n_checks++; if ({o_we_wb, o_wa} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL add_write: got %b/%0d exp 1/4", o_we_wb, o_wa); end
    n_checks++; if (rf[4] !== 16'h0000) begin n_fail++; $display("FAIL add_r4: got %h exp 0000", rf[4]); end
  endtask

  task automatic test_sub_cmp;
    run_cmd(3'd6, 3'd1, 3'd0, 3'd0, 16'h0005);
    run_cmd(3'd6, 3'd2, 3'd0, 3'd0, 16'h0007);
    run_cmd(3'd1, 3'd6, 3'd1, 3'd2, 16'h0000);
    n_checks++; if (o_data !== 16'hFFFE) begin n_fail++; $display("FAIL sub_data: got %h exp fffe", o_data); end
    n_checks++; if ({o_z, o_c} !== 2'b01) begin n_fail++; $display("FAIL sub_flags: zero,carry got %b exp 01", {o_z, o_c}); end
    n_checks++; if (rf[6] !== 16'hFFFE) begin n_fail++; $display("FAIL sub_r6: got %h exp fffe", rf[6]); end
    run_cmd(3'd7, 3'd3, 3'd2, 3'd1, 16'h0000);
    n_checks++; if (o_data !== 16'h0002) begin n_fail++; $display("FAIL cmp_data: got %h exp 0002", o_data); end
    n_checks++; if ({o_v_wb, o_z, o_c} !== 3'b100) begin n_fail++; $display("FAIL cmp_flags: valid,zero,carry got %b exp 100", {o_v_wb, o_z, o_c}); end
    n_checks++; if (o_we_wb !== 1'b0) begin n_fail++; $display("FAIL cmp_we: got %b exp 0", o_we_wb); end
    n_checks++; if (rf[3] !== 16'h1234) begin n_fail++; $display("FAIL cmp_r3_kept: got %h exp 1234", rf[3]); end
  endtask

  task automatic test_back_to_back;
    run_cmd(3'd6, 3'd7, 3'd0, 3'd0, 16'h00F0);
    cmd_op = 3'd4; cmd_rd = 3'd7; cmd_rs1 = 3'd7; cmd_rs2 = 3'd7; cmd_imm = '0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    // second command presented immediately and held; it must wait for cmd_ready
    cmd_op = 3'd3; cmd_rd = 3'd0;
    n_checks++; if ({cmd_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_exec1: ready,valid got %b exp 00", {cmd_ready, rsp_valid}); end
    @(posedge clk); #1;
    n_checks++; if ({cmd_ready, rsp_valid, rf_we, rf_addre_wr} !== {3'b011, 3'd7}) begin n_fail++; $display("FAIL b2b_wb1: got %b/%0d exp 011/7", {cmd_ready, rsp_valid, rf_we}, rf_addre_wr); end
    n_checks++; if ({rsp_data, rsp_zero} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL b2b_xor: data %h zero %b exp 0000 1", rsp_data, rsp_zero); end
    @(posedge clk); #1;
    n_checks++; if ({cmd_ready, rsp_valid, rf[7]} !== {2'b10, 16'h0000}) begin n_fail++; $display("FAIL b2b_idle: ready,valid %b r7 %h exp 10 0000", {cmd_ready, rsp_valid}, rf[7]); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++; if ({cmd_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL b2b_exec2: ready,valid got %b exp 00", {cmd_ready, rsp_valid}); end
    @(posedge clk); #1;
    n_checks++; if ({rsp_valid, rf_we, rf_addre_wr, rsp_data, rsp_zero} !== {2'b11, 3'd0, 16'h0000, 1'b1}) begin n_fail++; $display("FAIL b2b_or: valid,we %b addr %0d data %h zero %b exp 11 0 0000 1", {rsp_valid, rf_we}, rf_addre_wr, rsp_data, rsp_zero); end
    @(posedge clk); #1;
    n_checks++; if ({cmd_ready, rf[0]} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL b2b_r0: ready %b r0 %h exp 1 0000", cmd_ready, rf[0]); end
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] r2_before;
    int          seen;
    r2_before = rf[2];
    seen = 0;
    cmd_op = 3'd6; cmd_rd = 3'd2; cmd_imm = 16'hBEEF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; rst = 1'b1;
    seen += int'(rf_we) + int'(rsp_valid);
    @(posedge clk); #1;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 0", cmd_ready); end
    seen += int'(rf_we) + int'(rsp_valid);
    rst = 1'b0; #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_idle: ready got %b exp 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen += int'(rf_we) + int'(rsp_valid);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL mid_no_activity: pulses got %0d exp 0", seen); end
    n_checks++; if (rf[2] !== r2_before) begin n_fail++; $display("FAIL mid_r2: got %h exp %h", rf[2], r2_before); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_end: got %b exp 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_ldi_mov();
    test_add_carry();
    test_sub_cmp();
    test_back_to_back();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Command-driven initiator for the 8x16-bit, 2-read/1-write register file.
- Accepts one register-register operation per command over a valid/ready handshake.
- Drives the two read addresses, computes the ALU result and drives the write port.
- Returns the result and flags on a one-cycle response strobe.
- Sits between the control/decode logic and the register file, and is the only writer of the register file.

Parameters:
- DW, 16, data width; must match the register file word width.
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  operation code (see Behaviour)
- cmd_rd  in  AW  destination register
- cmd_rs1  in  AW  source A register
- cmd_rs2  in  AW  source B register
- cmd_imm  in  DW  immediate, used by LDI only
- rf_addre_rdA  out  AW  register file read address A
- rf_addre_rdB  out  AW  register file read address B
- rf_QA  in  DW  register file read data A (combinational from rf_addre_rdA)
- rf_QB  in  DW  register file read data B
- rf_D  out  DW  register file write data
- rf_addre_wr  out  AW  register file write address
- rf_we  out  1  register file write enable
- rsp_valid  out  1  one-cycle pulse: result available
- rsp_data  out  DW  result value
- rsp_zero  out  1  result == 0
- rsp_carry  out  1  carry out (ADD) / borrow (SUB, CMP); 0 for all other ops

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - cmd_ready=0 while rst is high.
  - rf_we, rsp_valid, rsp_zero and rsp_carry are 0.
  - rf_D, rsp_data, rf_addre_* are 0.
  - Reset mid-operation abandons the command: no write and no response.
- Opcodes:
  - 0 ADD: A+B, 17-bit sum, carry = bit 16
  - 1 SUB: A-B, carry = borrow (A<B unsigned)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MOV: result A
  - 6 LDI: result cmd_imm, no reads needed
  - 7 CMP: A-B flags only, no register write
- FSM states: IDLE -> EXEC -> WB -> IDLE.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid & cmd_ready) latches op, rd, rs1, rs2 and imm, then goes to EXEC.
  - Without a handshake, stay in IDLE.
- EXEC:
  - cmd_ready=0.
  - rf_addre_rdA and rf_addre_rdB driven from the latched rs1 and rs2.
  - ALU computes from rf_QA and rf_QB the same cycle.
  - Result and flags registered at the end of the cycle, then go to WB.
- WB:
  - cmd_ready=0.
  - rf_we=1, rf_addre_wr=rd, rf_D=result, except CMP, where rf_we=0.
  - rsp_valid=1 with rsp_data, rsp_zero and rsp_carry. rsp_data=A-B for CMP.
  - Go to IDLE.
- Latency and throughput:
  - Handshake at edge N -> EXEC during cycle N+1 -> WB during cycle N+2 (register written at end of N+2) -> cmd_ready=1 again in cycle N+3.
  - Throughput is one command per 3 cycles.
- Hazards: none by construction. A following command reads in its EXEC cycle, which is after the prior write edge.
- Source aliasing: rs1==rs2 and rd==rs1 are legal. Sources are read before the write.
- Read addresses outside EXEC hold their last value.
- rf_we is asserted only in WB, at most one cycle per command.
- rsp_valid has no backpressure. The consumer must sample it in the pulse cycle.
- cmd_* inputs are ignored while cmd_ready=0.
- Arithmetic wraps modulo 2^DW. Operands are unsigned.

Decomposition:
- Package regfile_pkg holds:
  - DW/AW constants.
  - enum op_e (OP_ADD..OP_CMP, 3 bits).
  - enum state_e (S_IDLE, S_EXEC, S_WB).
  - typedef cmd_t: struct of op, rd, rs1, rs2, imm.
- Sub-module regfile_alu is purely combinational: op, a, b, imm -> result, zero, carry.
- The FSM, command latch and output registers stay in regfile_op_sequencer.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then released.
  - Required: rf_we=0, rsp_valid=0; cmd_ready=0 during rst, =1 the first cycle after.
- LDI then read back:
  - Stimulus: LDI rd=3 imm=0x1234, then MOV rd=5 rs1=3.
  - Required: WB writes r3=0x1234, then r5=0x1234.
  - Required: each rsp_valid arrives 2 cycles after its handshake; cmd_ready returns 3 cycles after each handshake.
- ADD carry and zero:
  - Stimulus: r1=0xFFFF, r2=0x0001, ADD rd=4 rs1=1 rs2=2.
  - Required: r4=0x0000, rsp_zero=1, rsp_carry=1.
- SUB borrow and CMP:
  - Stimulus: r1=0x0005, r2=0x0007; SUB rd=6 rs1=1 rs2=2, then CMP rs1=2 rs2=1.
  - Required: SUB gives r6=0xFFFE, carry=1.
  - Required: CMP gives rsp_data=0x0002, carry=0, zero=0, and rf_we stays 0.
- Back-to-back dependency and aliasing:
  - Stimulus: r7=0x00F0; cmd_valid held high continuously with XOR rd=7 rs1=7 rs2=7, then OR rd=0 rs1=7 rs2=7.
  - Required: r7=0x0000, zero=1; then r0=0x0000.
  - Required: the second command is not accepted before cmd_ready returns.
- Reset mid-operation:
  - Stimulus: LDI rd=2 imm=0xBEEF, with rst asserted in its EXEC cycle.
  - Required: no rf_we pulse, no rsp_valid, r2 unchanged, FSM in IDLE after rst drops.
